// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: LB/LBU/LH/LHU/LW/SB/SH/SW over a req/ack data bus with wait states and timeout.
// Optional MEM_UNALIGNED_EXC_EN: misaligned LH/LHU/SH/LW/SW skip the bus and raise align_exc_o.
module mem_stage_hs #(
   parameter int ADDR_W      = 32,
   parameter int REG_AW      = 5,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] wd_i,
   input  logic              wreg_i,
   input  logic [31:0]       wdata_i,
   input  logic [7:0]        aluop_i,
   input  logic [31:0]       mem_addr_i,
   input  logic [31:0]       reg2_i,
   input  logic [31:0]       pc_i,
   output logic [REG_AW-1:0] wd_o,
   output logic              wreg_o,
   output logic [31:0]       wdata_o,
   output logic [31:0]       pc_o,
   output logic [7:0]        aluop_o,
   output logic              stallreq,
   output logic              dbus_req_o,
   output logic [3:0]        dbus_we_o,
   output logic [ADDR_W-1:0] dbus_addr_o,
   output logic [31:0]       dbus_wdata_o,
   input  logic              dbus_ack_i,
   input  logic [31:0]       dbus_rdata_i,
`ifdef MEM_UNALIGNED_EXC_EN
   output logic              align_exc_o,
`endif
   output logic              bus_err_o
);

   // Operation codes of the core's AluOpBus (8 bits)
   localparam logic [7:0] OP_LB  = 8'hE0;
   localparam logic [7:0] OP_LH  = 8'hE1;
   localparam logic [7:0] OP_LW  = 8'hE3;
   localparam logic [7:0] OP_LBU = 8'hE4;
   localparam logic [7:0] OP_LHU = 8'hE5;
   localparam logic [7:0] OP_SB  = 8'hE8;
   localparam logic [7:0] OP_SH  = 8'hE9;
   localparam logic [7:0] OP_SW  = 8'hEB;

`ifdef MEM_UNALIGNED_EXC_EN
   localparam bit ALIGN_EXC_EN = 1'b1;
`else
   localparam bit ALIGN_EXC_EN = 1'b0;
`endif

   localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [31:0]      data_reg, data_next;
   logic             err_reg, err_next;
   logic             align_reg, align_next;

   logic        is_load, is_store, is_mem;
   logic        size_b, size_h, size_w, ld_signed;
   logic        misaligned, align_hit;
   logic        bus_act;
   logic [7:0]  rd_byte [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_val;
   logic [3:0]  st_we;
   logic [31:0] st_data;
   logic [ADDR_W-1:0] bus_addr;

   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      size_b    = 1'b0;
      size_h    = 1'b0;
      size_w    = 1'b0;
      ld_signed = 1'b0;
      case (aluop_i)
         OP_LB:  begin is_load  = 1'b1; size_b = 1'b1; ld_signed = 1'b1; end
         OP_LBU: begin is_load  = 1'b1; size_b = 1'b1; end
         OP_LH:  begin is_load  = 1'b1; size_h = 1'b1; ld_signed = 1'b1; end
         OP_LHU: begin is_load  = 1'b1; size_h = 1'b1; end
         OP_LW:  begin is_load  = 1'b1; size_w = 1'b1; end
         OP_SB:  begin is_store = 1'b1; size_b = 1'b1; end
         OP_SH:  begin is_store = 1'b1; size_h = 1'b1; end
         OP_SW:  begin is_store = 1'b1; size_w = 1'b1; end
         default: ;
      endcase
   end

   assign is_mem     = is_load | is_store;
   assign misaligned = (size_h & mem_addr_i[0]) | (size_w & (mem_addr_i[1:0] != 2'b00));
   assign align_hit  = ALIGN_EXC_EN & misaligned;
   assign bus_addr   = {mem_addr_i[ADDR_W-1:2], 2'b00};

   // Big-endian lane order: byte 0 lives in [31:24]
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign rd_byte[gi] = dbus_rdata_i[31-8*gi -: 8];
      end
   endgenerate

   // Halfword lane uses addr[1] only, so misaligned halves fall back to the aligned lane
   always_comb begin
      byte_sel = rd_byte[mem_addr_i[1:0]];
      half_sel = mem_addr_i[1] ? dbus_rdata_i[15:0] : dbus_rdata_i[31:16];
      load_val = dbus_rdata_i;
      if (size_b) begin
         load_val = {{24{ld_signed & byte_sel[7]}}, byte_sel};
      end else if (size_h) begin
         load_val = {{16{ld_signed & half_sel[15]}}, half_sel};
      end
   end

   always_comb begin
      st_we   = 4'b0000;
      st_data = reg2_i;
      if (is_store) begin
         if (size_b) begin
            st_we   = 4'b1000 >> mem_addr_i[1:0];
            st_data = {4{reg2_i[7:0]}};
         end else if (size_h) begin
            st_we   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            st_data = {2{reg2_i[15:0]}};
         end else begin
            st_we   = 4'b1111;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         data_reg  <= '0;
         err_reg   <= 1'b0;
         align_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         data_reg  <= data_next;
         err_reg   <= err_next;
         align_reg <= align_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      data_next    = data_reg;
      err_next     = err_reg;
      align_next   = align_reg;
      bus_act      = 1'b0;
      wd_o         = wd_i;
      wreg_o       = 1'b0;
      wdata_o      = '0;
      pc_o         = pc_i;
      aluop_o      = aluop_i;
      stallreq     = 1'b0;
      dbus_req_o   = 1'b0;
      dbus_we_o    = 4'b0000;
      dbus_addr_o  = '0;
      dbus_wdata_o = '0;
      bus_err_o    = 1'b0;

      case (state_reg)
         S_IDLE: begin
            cnt_next   = '0;
            err_next   = 1'b0;
            align_next = 1'b0;
            if (!is_mem) begin
               wreg_o  = wreg_i;
               wdata_o = wdata_i;
            end else if (align_hit) begin
               stallreq   = 1'b1;
               align_next = 1'b1;
               state_next = S_DONE;
            end else begin
               stallreq = 1'b1;
               bus_act  = 1'b1;
               if (dbus_ack_i) begin
                  state_next = S_DONE;
               end else begin
                  cnt_next   = CNT_W'(1);
                  state_next = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            stallreq = 1'b1;
            bus_act  = 1'b1;
            if (dbus_ack_i) begin
               state_next = S_DONE;
            end else if (cnt_reg == CNT_LAST) begin
               err_next   = 1'b1;
               state_next = S_DONE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_DONE: begin
            bus_err_o = err_reg;
            // Only a successful load writes back; stores and failed accesses are squashed
            if (is_load && !err_reg && !align_reg) begin
               wreg_o  = wreg_i;
               wdata_o = data_reg;
            end
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase

      if (bus_act) begin
         dbus_req_o   = 1'b1;
         dbus_we_o    = st_we;
         dbus_addr_o  = bus_addr;
         dbus_wdata_o = is_store ? st_data : 32'h0;
         if (dbus_ack_i) begin
            data_next = load_val;
         end
      end

      // While reset is asserted every output is held low, including the pass-through path
      if (!rst) begin
         wd_o         = '0;
         wreg_o       = 1'b0;
         wdata_o      = '0;
         pc_o         = '0;
         aluop_o      = '0;
         stallreq     = 1'b0;
         dbus_req_o   = 1'b0;
         dbus_we_o    = 4'b0000;
         dbus_addr_o  = '0;
         dbus_wdata_o = '0;
         bus_err_o    = 1'b0;
      end
   end

`ifdef MEM_UNALIGNED_EXC_EN
   assign align_exc_o = rst & (state_reg == S_DONE) & align_reg;
`endif

endmodule

// File: tb/tb_mem_stage_hs.sv
// Scoreboard bench for mem_stage_hs: driver pushes expected results, monitor pops on completion.
`timescale 1ns/1ps
module tb_mem_stage_hs;

   localparam logic [7:0] OP_NOP = 8'h00;
   localparam logic [7:0] OP_ADD = 8'h20;
   localparam logic [7:0] OP_LB  = 8'hE0;
   localparam logic [7:0] OP_LH  = 8'hE1;
   localparam logic [7:0] OP_LW  = 8'hE3;
   localparam logic [7:0] OP_LBU = 8'hE4;
   localparam logic [7:0] OP_LHU = 8'hE5;
   localparam logic [7:0] OP_SB  = 8'hE8;
   localparam logic [7:0] OP_SH  = 8'hE9;
   localparam logic [7:0] OP_SW  = 8'hEB;

   logic        clk;
   logic        rst;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] wdata_i;
   logic [7:0]  aluop_i;
   logic [31:0] mem_addr_i;
   logic [31:0] reg2_i;
   logic [31:0] pc_i;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic [31:0] pc_o;
   logic [7:0]  aluop_o;
   logic        stallreq;
   logic        dbus_req_o;
   logic [3:0]  dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [31:0] dbus_wdata_o;
   logic        dbus_ack_i;
   logic [31:0] dbus_rdata_i;
   logic        bus_err_o;
`ifdef MEM_UNALIGNED_EXC_EN
   logic        align_exc_o;
`endif

   mem_stage_hs #(.ADDR_W(32), .REG_AW(5), .TIMEOUT_CYC(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .wd_i         (wd_i),
      .wreg_i       (wreg_i),
      .wdata_i      (wdata_i),
      .aluop_i      (aluop_i),
      .mem_addr_i   (mem_addr_i),
      .reg2_i       (reg2_i),
      .pc_i         (pc_i),
      .wd_o         (wd_o),
      .wreg_o       (wreg_o),
      .wdata_o      (wdata_o),
      .pc_o         (pc_o),
      .aluop_o      (aluop_o),
      .stallreq     (stallreq),
      .dbus_req_o   (dbus_req_o),
      .dbus_we_o    (dbus_we_o),
      .dbus_addr_o  (dbus_addr_o),
      .dbus_wdata_o (dbus_wdata_o),
      .dbus_ack_i   (dbus_ack_i),
      .dbus_rdata_i (dbus_rdata_i),
`ifdef MEM_UNALIGNED_EXC_EN
      .align_exc_o  (align_exc_o),
`endif
      .bus_err_o    (bus_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wreg;
      logic [31:0] wdata;
      logic [4:0]  wd;
      logic        err;
      logic        aexc;
      int          stalls;
      logic        req;
      logic [3:0]  we;
      logic [31:0] baddr;
      logic [31:0] bwdata;
      logic [31:0] pc;
      logic [7:0]  op;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          delay_cfg = 0;
   logic [31:0] rdata_cfg = 32'h0;
   logic        stray_ack = 1'b0;
   logic [31:0] pc_cnt = 32'h0000_1000;
   logic [4:0]  wd_cnt = 5'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Bus slave: acks on the delay_cfg-th request cycle (never if negative)
   initial begin
      int req_cyc;
      req_cyc      = 0;
      dbus_ack_i   = 1'b0;
      dbus_rdata_i = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         if (dbus_req_o) begin
            dbus_ack_i   = (req_cyc == delay_cfg);
            dbus_rdata_i = rdata_cfg;
            req_cyc++;
         end else begin
            dbus_ack_i   = stray_ack;
            dbus_rdata_i = 32'hFFFF_FFFF;
            req_cyc      = 0;
         end
      end
   end

   // Monitor: counts stall cycles, records bus activity, compares when stallreq drops
   initial begin
      int          stalls;
      logic        seen;
      logic [3:0]  b_we;
      logic [31:0] b_addr, b_wdata;
      exp_t        e;
      stalls = 0; seen = 1'b0; b_we = 4'b0; b_addr = 32'h0; b_wdata = 32'h0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            stalls = 0;
            seen   = 1'b0;
         end else if (exp_q.size() != 0 && stallreq) begin
            stalls++;
            if (dbus_req_o) begin
               seen    = 1'b1;
               b_we    = dbus_we_o;
               b_addr  = dbus_addr_o;
               b_wdata = dbus_wdata_o;
            end
            check("bus_err_busy", 32'(bus_err_o), 32'd0);
         end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wreg_o", 32'(wreg_o), 32'(e.wreg));
            if (e.wreg || e.err) check("wdata_o", wdata_o, e.wdata);
            if (e.wreg) check("wd_o", 32'(wd_o), 32'(e.wd));
            check("bus_err_o", 32'(bus_err_o), 32'(e.err));
            check("stall_cycles", 32'(stalls), 32'(e.stalls));
            check("req_seen", 32'(seen), 32'(e.req));
            check("pc_o", pc_o, e.pc);
            check("aluop_o", 32'(aluop_o), 32'(e.op));
            if (e.req) begin
               check("dbus_we_o", 32'(b_we), 32'(e.we));
               check("dbus_addr_o", b_addr, e.baddr);
               if (e.we != 4'b0000) check("dbus_wdata_o", b_wdata, e.bwdata);
            end
`ifdef MEM_UNALIGNED_EXC_EN
            check("align_exc_o", 32'(align_exc_o), 32'(e.aexc));
`endif
            $display("txn pc=%08h op=%02h wreg=%0b wdata=%08h err=%0b stalls=%0d",
                     pc_o, aluop_o, wreg_o, wdata_o, bus_err_o, stalls);
            stalls = 0;
            seen   = 1'b0;
         end else begin
            check("bus_err_idle", 32'(bus_err_o), 32'd0);
         end
      end
   end

   task automatic run(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                      input logic [31:0] rdata, input int delay, input logic [31:0] wdata_in,
                      input logic xwreg, input logic [31:0] xwdata, input int xstalls,
                      input logic xerr, input logic xaexc, input logic [3:0] xwe,
                      input logic [31:0] xbwdata);
      exp_t e;
      int   guard;
      @(posedge clk);
      #1;
      pc_cnt     = pc_cnt + 32'd4;
      wd_cnt     = wd_cnt + 5'd1;
      aluop_i    = op;
      mem_addr_i = addr;
      reg2_i     = reg2;
      pc_i       = pc_cnt;
      wd_i       = wd_cnt;
      wreg_i     = 1'b1;
      wdata_i    = wdata_in;
      delay_cfg  = delay;
      rdata_cfg  = rdata;
      e.wreg   = xwreg;
      e.wdata  = xwdata;
      e.wd     = wd_cnt;
      e.err    = xerr;
      e.aexc   = xaexc;
      e.stalls = xstalls;
      e.req    = (xstalls > 0) && !xaexc;
      e.we     = xwe;
      e.baddr  = {addr[31:2], 2'b00};
      e.bwdata = xbwdata;
      e.pc     = pc_cnt;
      e.op     = op;
      exp_q.push_back(e);
      guard = 0;
      @(negedge clk);
      while (stallreq === 1'b1) begin
         guard++;
         if (guard > 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL stall_timeout: stallreq still 1 after %0d cycles, expected release", guard);
            exp_q.delete();
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b0;
      aluop_i    = OP_LW;
      mem_addr_i = 32'h0000_0100;
      reg2_i     = 32'h1234_5678;
      pc_i       = 32'hABCD_0000;
      wd_i       = 5'd3;
      wreg_i     = 1'b1;
      wdata_i    = 32'h7777_7777;

      // Reset state: everything low even with a memory op presented
      repeat (2) @(negedge clk);
      check("rst_stallreq", 32'(stallreq), 32'd0);
      check("rst_req", 32'(dbus_req_o), 32'd0);
      check("rst_wreg", 32'(wreg_o), 32'd0);
      check("rst_wdata", wdata_o, 32'd0);
      check("rst_pc", pc_o, 32'd0);
      check("rst_bus_err", 32'(bus_err_o), 32'd0);
      aluop_i = OP_NOP;
      @(posedge clk);
      #1 rst = 1'b1;

      //  op      addr          reg2          rdata         dly  wdata_in      wreg xwdata        stl err aex we       bwdata
      run(OP_LW,  32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 3, 32'h1111_1111, 1, 32'hDEAD_BEEF, 4, 0, 0, 4'b0000, 32'h0);
      run(OP_LB,  32'h0000_0103, 32'h0,        32'h0000_00F0, 0, 32'h1111_1111, 1, 32'hFFFF_FFF0, 1, 0, 0, 4'b0000, 32'h0);
      run(OP_LBU, 32'h0000_0103, 32'h0,        32'h0000_00F0, 0, 32'h1111_1111, 1, 32'h0000_00F0, 1, 0, 0, 4'b0000, 32'h0);
      run(OP_LH,  32'h0000_0102, 32'h0,        32'h1234_8001, 1, 32'h1111_1111, 1, 32'hFFFF_8001, 2, 0, 0, 4'b0000, 32'h0);
      run(OP_LHU, 32'h0000_0100, 32'h0,        32'h8001_1234, 0, 32'h1111_1111, 1, 32'h0000_8001, 1, 0, 0, 4'b0000, 32'h0);
      run(OP_LB,  32'h0000_0101, 32'h0,        32'h1280_3456, 0, 32'h1111_1111, 1, 32'hFFFF_FF80, 1, 0, 0, 4'b0000, 32'h0);
      run(OP_LHU, 32'h0000_0102, 32'h0,        32'h0000_FFFE, 0, 32'h1111_1111, 1, 32'h0000_FFFE, 1, 0, 0, 4'b0000, 32'h0);
      run(OP_LBU, 32'h0000_0100, 32'h0,        32'h7F00_0000, 0, 32'h1111_1111, 1, 32'h0000_007F, 1, 0, 0, 4'b0000, 32'h0);
      run(OP_SH,  32'h0000_0102, 32'h1234_ABCD, 32'h0,        0, 32'h1111_1111, 0, 32'h0,        1, 0, 0, 4'b0011, 32'hABCD_ABCD);
      run(OP_SB,  32'h0000_0101, 32'h0000_00A5, 32'h0,        2, 32'h1111_1111, 0, 32'h0,        3, 0, 0, 4'b0100, 32'hA5A5_A5A5);
      run(OP_SW,  32'h0000_010C, 32'hCAFE_F00D, 32'h0,        0, 32'h1111_1111, 0, 32'h0,        1, 0, 0, 4'b1111, 32'hCAFE_F00D);

      // Pass-through with a stray ack that must be ignored
      stray_ack = 1'b1;
      run(OP_ADD, 32'h0000_0100, 32'h0,        32'h0,         0, 32'h55AA_1234, 1, 32'h55AA_1234, 0, 0, 0, 4'b0000, 32'h0);
      stray_ack = 1'b0;

      // No ack: 16 stall cycles then error pulse, result squashed
      run(OP_LW,  32'h0000_0104, 32'h0,        32'h0,        -1, 32'h1111_1111, 0, 32'h0,        16, 1, 0, 4'b0000, 32'h0);
      run(OP_ADD, 32'h0,         32'h0,        32'h0,         0, 32'h0F0F_0F0F, 1, 32'h0F0F_0F0F, 0, 0, 0, 4'b0000, 32'h0);

      // Reset asserted while waiting for ack
      @(posedge clk);
      #1;
      aluop_i    = OP_LW;
      mem_addr_i = 32'h0000_0180;
      delay_cfg  = -1;
      repeat (3) @(negedge clk);
      check("wait_stallreq", 32'(stallreq), 32'd1);
      check("wait_req", 32'(dbus_req_o), 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("midrst_req", 32'(dbus_req_o), 32'd0);
      check("midrst_stallreq", 32'(stallreq), 32'd0);
      check("midrst_wreg", 32'(wreg_o), 32'd0);
      aluop_i = OP_NOP;
      @(posedge clk);
      #1 rst = 1'b1;
      run(OP_LW,  32'h0000_0200, 32'h0,        32'h0102_0304, 1, 32'h1111_1111, 1, 32'h0102_0304, 2, 0, 0, 4'b0000, 32'h0);

`ifdef MEM_UNALIGNED_EXC_EN
      run(OP_LW,  32'h0000_0101, 32'h0,        32'hA1B2_C3D4, 0, 32'h1111_1111, 0, 32'h0,        1, 0, 1, 4'b0000, 32'h0);
      run(OP_LH,  32'h0000_0101, 32'h0,        32'h89AB_0000, 0, 32'h1111_1111, 0, 32'h0,        1, 0, 1, 4'b0000, 32'h0);
      run(OP_SH,  32'h0000_0103, 32'h0000_BEEF, 32'h0,        0, 32'h1111_1111, 0, 32'h0,        1, 0, 1, 4'b0000, 32'h0);
`else
      run(OP_LW,  32'h0000_0101, 32'h0,        32'hA1B2_C3D4, 0, 32'h1111_1111, 1, 32'hA1B2_C3D4, 1, 0, 0, 4'b0000, 32'h0);
      run(OP_LH,  32'h0000_0101, 32'h0,        32'h89AB_0000, 0, 32'h1111_1111, 1, 32'hFFFF_89AB, 1, 0, 0, 4'b0000, 32'h0);
      run(OP_SH,  32'h0000_0103, 32'h0000_BEEF, 32'h0,        0, 32'h1111_1111, 0, 32'h0,        1, 0, 0, 4'b0011, 32'hBEEF_BEEF);
`endif
      run(OP_SW,  32'h0000_0200, 32'h0BAD_F00D, 32'h0,        0, 32'h1111_1111, 0, 32'h0,        1, 0, 0, 4'b1111, 32'h0BAD_F00D);

      repeat (3) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
